// File: rtl/sccb_config_sequencer.sv
// Walks a synchronous register-table ROM and issues one SCCB write per entry via sccb_interface.
// Define SCCB_SEQ_TIMEOUT_EN to add a handshake watchdog that drives seq_error.
module sccb_config_sequencer #(
  parameter int unsigned CLK_FREQ   = 25000000,
  parameter int unsigned POWERUP_MS = 10,
  parameter int unsigned ROM_AW     = 8,
  parameter logic [7:0]  DELAY_TAG  = 8'hF0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              init_start,
  input  logic              sccb_ready,
  input  logic [15:0]       rom_data,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              sccb_start,
  output logic [7:0]        sccb_addr,
  output logic [7:0]        sccb_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        write_count,
  output logic              seq_error
);

  localparam int unsigned       TICK_CYC  = (CLK_FREQ >= 1000) ? (CLK_FREQ / 1000) : 1;
  localparam int unsigned       TICK_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
  localparam int unsigned       MS_W      = 16;
  localparam logic [ROM_AW-1:0] ADDR_LAST = {ROM_AW{1'b1}};
`ifdef SCCB_SEQ_TIMEOUT_EN
  localparam int unsigned DONE_CYC     = ((20 * CLK_FREQ) / 100000 > 0) ? ((20 * CLK_FREQ) / 100000) : 1;
  localparam logic [23:0] WD_BUSY_LAST = 24'd15;
  localparam logic [23:0] WD_DONE_LAST = 24'(DONE_CYC - 1);
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_WAIT_ROM, S_DECODE,
    S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_DELAY, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic                start_q, start_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic [15:0]         entry_q, entry_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [MS_W-1:0]     ms_q, ms_d;
`ifdef SCCB_SEQ_TIMEOUT_EN
  logic [23:0]         wd_q, wd_d;
  logic                err_q, err_d;
`endif
  logic                tick_s, ms_zero_s, ms_last_s, advance_s, finish_s;

  assign tick_s    = (tick_q == TICK_LAST);
  assign ms_zero_s = (ms_q == {MS_W{1'b0}});
  assign ms_last_s = tick_s && (ms_q == MS_W'(1));

  // Next-state and datapath decode for the table walk
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    start_d    = start_q;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    wcnt_d     = wcnt_q;
    entry_d    = entry_q;
    tick_d     = tick_q;
    ms_d       = ms_q;
    advance_s  = 1'b0;
    finish_s   = 1'b0;
`ifdef SCCB_SEQ_TIMEOUT_EN
    wd_d       = wd_q;
    err_d      = err_q;
`endif

    // Shared ms timebase for power-up and delay entries; state entry overrides below
    if ((state_q == S_PWRUP || state_q == S_DELAY) && !ms_zero_s) begin
      tick_d = tick_s ? {TICK_W{1'b0}} : tick_q + TICK_W'(1);
      ms_d   = tick_s ? ms_q - MS_W'(1) : ms_q;
    end else begin
      tick_d = tick_q;
    end

    case (state_q)
      S_IDLE: begin
        if (init_start && sccb_ready) begin
          busy_d     = 1'b1;
          done_d     = 1'b0;
          wcnt_d     = 8'd0;
          rom_addr_d = {ROM_AW{1'b0}};
          tick_d     = {TICK_W{1'b0}};
          ms_d       = MS_W'(POWERUP_MS);
          state_d    = S_PWRUP;
`ifdef SCCB_SEQ_TIMEOUT_EN
          err_d      = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PWRUP: begin
        if (ms_zero_s || ms_last_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_PWRUP;
        end
      end
      S_FETCH:    state_d = S_WAIT_ROM;
      S_WAIT_ROM: begin
        entry_d = rom_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (entry_q == 16'hFFFF) begin
          finish_s = 1'b1;
        end else if (entry_q[15:8] == DELAY_TAG) begin
          ms_d    = {8'h00, entry_q[7:0]};
          tick_d  = {TICK_W{1'b0}};
          state_d = S_DELAY;
        end else if (entry_q[15:8] == 8'hFE) begin
          // 0xFE selects a read in sccb_interface, so it is never written
          advance_s = 1'b1;
        end else begin
          addr_d  = entry_q[15:8];
          data_d  = entry_q[7:0];
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        start_d = 1'b0;
        state_d = S_WAIT_BUSY;
`ifdef SCCB_SEQ_TIMEOUT_EN
        wd_d    = 24'd0;
`endif
      end
      S_WAIT_BUSY: begin
        if (!sccb_ready) begin
          state_d = S_WAIT_DONE;
`ifdef SCCB_SEQ_TIMEOUT_EN
          wd_d    = 24'd0;
        end else if (wd_q == WD_BUSY_LAST) begin
          err_d    = 1'b1;
          finish_s = 1'b1;
        end else begin
          wd_d = wd_q + 24'd1;
`else
        end else begin
          state_d = S_WAIT_BUSY;
`endif
        end
      end
      S_WAIT_DONE: begin
        if (sccb_ready) begin
          wcnt_d    = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
          advance_s = 1'b1;
`ifdef SCCB_SEQ_TIMEOUT_EN
        end else if (wd_q == WD_DONE_LAST) begin
          err_d    = 1'b1;
          finish_s = 1'b1;
        end else begin
          wd_d = wd_q + 24'd1;
`else
        end else begin
          state_d = S_WAIT_DONE;
`endif
        end
      end
      S_DELAY: begin
        if (ms_zero_s || ms_last_s) begin
          advance_s = 1'b1;
        end else begin
          state_d = S_DELAY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Consuming the last table index without an end marker ends the pass
    if (finish_s || (advance_s && (rom_addr_q == ADDR_LAST))) begin
      state_d = S_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end else if (advance_s) begin
      rom_addr_d = rom_addr_q + ROM_AW'(1);
      state_d    = S_FETCH;
    end else begin
      rom_addr_d = rom_addr_d;
    end
  end

  // State register, advanced only on clk_en cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rom_addr_q <= {ROM_AW{1'b0}};
      start_q    <= 1'b0;
      addr_q     <= 8'd0;
      data_q     <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wcnt_q     <= 8'd0;
      entry_q    <= 16'd0;
      tick_q     <= {TICK_W{1'b0}};
      ms_q       <= {MS_W{1'b0}};
`ifdef SCCB_SEQ_TIMEOUT_EN
      wd_q       <= 24'd0;
      err_q      <= 1'b0;
`endif
    end else if (clk_en) begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      start_q    <= start_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wcnt_q     <= wcnt_d;
      entry_q    <= entry_d;
      tick_q     <= tick_d;
      ms_q       <= ms_d;
`ifdef SCCB_SEQ_TIMEOUT_EN
      wd_q       <= wd_d;
      err_q      <= err_d;
`endif
    end
  end

  assign rom_addr    = rom_addr_q;
  assign sccb_start  = start_q;
  assign sccb_addr   = addr_q;
  assign sccb_data   = data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign write_count = wcnt_q;
`ifdef SCCB_SEQ_TIMEOUT_EN
  assign seq_error   = err_q;
`else
  assign seq_error   = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Directed bench for sccb_config_sequencer: ROM model, sccb_interface responder, start/clk_en monitor.
module tb_sccb_config_sequencer;
  localparam int AW = 4;

  logic          clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, init_start = 1'b0, sccb_ready = 1'b1;
  logic [15:0]   rom_data;
  logic [AW-1:0] rom_addr;
  logic          sccb_start, busy, done, seq_error;
  logic [7:0]    sccb_addr, sccb_data, write_count;

  logic [15:0] rom [16];
  int          cyc = 0, n_assert = 0, n_fail = 0;
  int          n_start = 0, width = 0, wviol = 0, sviol = 0, rcnt = 0;
  logic [7:0]  st_addr [8];
  logic [7:0]  st_data [8];
  int          st_cyc [8];
  logic        start_prev = 1'b0, en_prev = 1'b1, tog = 1'b0, stuck = 1'b0;
  logic [31:0] snap = 32'd0;

  sccb_config_sequencer #(.CLK_FREQ(100000), .POWERUP_MS(1), .ROM_AW(AW), .DELAY_TAG(8'hF0)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .init_start(init_start), .sccb_ready(sccb_ready),
    .rom_data(rom_data), .rom_addr(rom_addr), .sccb_start(sccb_start), .sccb_addr(sccb_addr),
    .sccb_data(sccb_data), .busy(busy), .done(done), .write_count(write_count), .seq_error(seq_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (clk_en) rom_data <= rom[rom_addr];
  always @(posedge clk) begin
    #2;
    clk_en = tog ? ~clk_en : 1'b1;
  end

  // At each negedge clk_en holds the value the next posedge will use
  always @(negedge clk) begin
    if (rst_n) begin
      if (!en_prev && snap !== {rom_addr, sccb_start, sccb_addr, sccb_data, busy, done, write_count, seq_error})
        sviol++;
      snap    = {rom_addr, sccb_start, sccb_addr, sccb_data, busy, done, write_count, seq_error};
      en_prev = clk_en;
    end else begin
      en_prev = 1'b1;
    end
    if (sccb_start && !start_prev) begin
      if (n_start < 8) begin
        st_addr[n_start] = sccb_addr;
        st_data[n_start] = sccb_data;
        st_cyc[n_start]  = cyc;
      end
      n_start++;
      width = 0;
    end
    if (sccb_start && clk_en) width++;
    if (!sccb_start && start_prev && width != 1) wviol++;
    start_prev = sccb_start;
    if (clk_en) begin
      if (sccb_start && !stuck) begin
        sccb_ready = 1'b0;
        rcnt       = 3;
      end else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) sccb_ready = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_pass(output int t0);
    int k;
    k = 0;
    @(negedge clk);
    init_start = 1'b1;
    while (busy !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    init_start = 1'b0;
    t0 = cyc;
    chk("accept", busy, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, done, 1);
  endtask

  task automatic load3(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
    rom[0] = e0;
    rom[1] = e1;
    rom[2] = e2;
    n_start = 0;
  endtask

  initial begin
    int t0;
    int k;
    load3(16'h1280, 16'h1100, 16'hFFFF);
    repeat (3) @(negedge clk);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_start", sccb_start, 0);
    chk("rst_addr_data", {sccb_addr, sccb_data}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_wcnt_err", {write_count, seq_error}, 0);
    rst_n = 1'b1;

    // two writes; 100 power-up cycles then FETCH/WAIT_ROM/DECODE -> start 103 cycles after accept
    run_pass(t0);
    wait_done("t1_done", 400);
    chk("t1_nstart", n_start, 2);
    chk("t1_w0", {st_addr[0], st_data[0]}, 16'h1280);
    chk("t1_w1", {st_addr[1], st_data[1]}, 16'h1100);
    chk("t1_first_lat", st_cyc[0] - t0, 103);
    chk("t1_gap", st_cyc[1] - st_cyc[0], 7);
    chk("t1_wcnt", write_count, 2);
    chk("t1_busy", busy, 0);
    chk("t1_rom_addr", rom_addr, 2);
    chk("t1_err", seq_error, 0);
    repeat (2) @(negedge clk);
    chk("t1_done_sticky", done, 1);

    // 5 ms delay: decode at 103, 500 delay cycles, then 3 more to start
    load3(16'hF005, 16'h1234, 16'hFFFF);
    run_pass(t0);
    chk("t2_restart_addr", rom_addr, 0);
    chk("t2_done_cleared", done, 0);
    wait_done("t2_done", 1000);
    chk("t2_nstart", n_start, 1);
    chk("t2_w0", {st_addr[0], st_data[0]}, 16'h1234);
    chk("t2_delay_lat", st_cyc[0] - t0, 606);
    chk("t2_wcnt", write_count, 1);

    // 0xFE skipped; a stray init_start while busy must not restart the pass
    load3(16'hFE55, 16'h0A0B, 16'hFFFF);
    run_pass(t0);
    repeat (10) @(negedge clk);
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    wait_done("t3_done", 400);
    chk("t3_nstart", n_start, 1);
    chk("t3_w0", {st_addr[0], st_data[0]}, 16'h0A0B);
    chk("t3_skip_lat", st_cyc[0] - t0, 106);
    chk("t3_wcnt", write_count, 1);

    // clk_en alternating
    load3(16'h1280, 16'h1100, 16'hFFFF);
    sviol = 0;
    tog = 1'b1;
    run_pass(t0);
    wait_done("t4_done", 1000);
    chk("t4_nstart", n_start, 2);
    chk("t4_w0", {st_addr[0], st_data[0]}, 16'h1280);
    chk("t4_w1", {st_addr[1], st_data[1]}, 16'h1100);
    chk("t4_wcnt", write_count, 2);
    chk("t4_hold_on_disabled", sviol, 0);
    tog = 1'b0;
    repeat (4) @(negedge clk);

    // async reset while waiting for sccb_ready to return
    load3(16'h1280, 16'h1100, 16'hFFFF);
    run_pass(t0);
    k = 0;
    while (n_start < 1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk("t5_inflight", {busy, sccb_ready}, 2'b10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy_done", {busy, done}, 0);
    chk("t5_rst_addr", {rom_addr, sccb_start, sccb_addr, sccb_data}, 0);
    chk("t5_rst_wcnt", write_count, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_start = 0;
    run_pass(t0);
    chk("t5_restart_addr", rom_addr, 0);
    wait_done("t5_done", 400);
    chk("t5_first_lat", st_cyc[0] - t0, 103);
    chk("t5_w0", {st_addr[0], st_data[0]}, 16'h1280);
    chk("t5_wcnt", write_count, 2);

    // init_start held off while sccb_ready is low, then accepted
    n_start = 0;
    @(negedge clk);
    sccb_ready = 1'b0;
    init_start = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_held_off", busy, 0);
    sccb_ready = 1'b1;
    @(negedge clk);
    chk("t6_accepted", busy, 1);
    init_start = 1'b0;
    wait_done("t6_done", 400);
    chk("t6_wcnt", write_count, 2);

    // no end marker: last index consumed ends the pass without wrapping
    for (int i = 0; i < 16; i++) rom[i] = 16'hFE00;
    n_start = 0;
    run_pass(t0);
    wait_done("t7_done", 500);
    chk("t7_rom_addr", rom_addr, 15);
    chk("t7_wcnt", write_count, 0);
    chk("t7_nstart", n_start, 0);

    // responder never drops sccb_ready
    load3(16'h1280, 16'hFFFF, 16'hFFFF);
    stuck = 1'b1;
    run_pass(t0);
    k = 0;
    while (n_start < 1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("t8_started", n_start, 1);
    k = 0;
    while (cyc < st_cyc[0] + 16 && k < 100) begin
      @(negedge clk);
      k++;
    end
`ifdef SCCB_SEQ_TIMEOUT_EN
    chk("t8_not_yet", done, 0);
    @(negedge clk);
    chk("t8_timeout_done", {busy, done}, 2'b01);
    chk("t8_seq_error", seq_error, 1);
    chk("t8_wcnt", write_count, 0);
`else
    repeat (200) @(negedge clk);
    chk("t8_stuck_busy_done", {busy, done}, 2'b10);
    chk("t8_no_error", seq_error, 0);
    chk("t8_wcnt", write_count, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t8_rst_busy", busy, 0);
    rst_n = 1'b1;
`endif
    stuck = 1'b0;
    repeat (3) @(negedge clk);
    n_start = 0;
    run_pass(t0);
    chk("t8_err_cleared", seq_error, 0);
    wait_done("t8_rerun_done", 400);
    chk("t8_rerun_wcnt", write_count, 1);
    chk("start_width", wviol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sccb_config_sequencer.md
Name: sccb_config_sequencer

Overview:
- Sequences camera register initialisation through sccb_interface: walks an external register table, issues one SCCB write per entry, honours delay and end markers, reports completion.
- Sits between top-level init control, a synchronous table ROM, and sccb_interface's start/address/data/ready handshake.
- Runs only on cycles where clk_en=1, sharing the enable used by sccb_interface.

Parameters:
- CLK_FREQ, 25000000, rate of clk_en-qualified cycles in Hz; sets the 1 ms tick.
- POWERUP_MS, 10, wait in ms after init_start before the first table fetch.
- ROM_AW, 8, table address width; table depth is 2**ROM_AW.
- DELAY_TAG, 8'hF0, entry address byte meaning "delay data ms".

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- clk_en, input, 1, clock enable; no state changes when 0.
- init_start, input, 1, level/pulse; sampled in S_IDLE to begin a pass.
- sccb_ready, input, 1, ready from sccb_interface.
- rom_data, input, 16, table entry {reg_addr[15:8], reg_data[7:0]}; valid 1 enabled cycle after rom_addr.
- rom_addr, output, ROM_AW, table index.
- sccb_start, output, 1, one enabled-cycle start pulse to sccb_interface.
- sccb_addr, output, 8, register address to sccb_interface.
- sccb_data, output, 8, register data to sccb_interface.
- busy, output, 1, high from accepted init_start until S_DONE.
- done, output, 1, high in S_DONE; sticky until next init_start.
- write_count, output, 8, SCCB writes completed this pass (saturates at 255).
- seq_error, output, 1, handshake timeout flag (see Optional Feature).

Behaviour:
- Reset values: rom_addr=0, sccb_start=0, sccb_addr=0, sccb_data=0, busy=0, done=0, write_count=0, seq_error=0, FSM=S_IDLE, counters=0. Asynchronous reset is honoured mid-transaction; no completion of an in-flight write is attempted.
- ms tick: a counter of CLK_FREQ/1000 enabled cycles. The counter is cleared when entering S_PWRUP and S_DELAY.
- S_IDLE:
  - Wait for init_start=1 and sccb_ready=1.
  - On that condition: busy<=1, done<=0, write_count<=0, rom_addr<=0, seq_error<=0, go to S_PWRUP.
  - init_start while sccb_ready=0 is held off; it is not lost if still asserted.
- S_PWRUP: count POWERUP_MS ticks, then go to S_FETCH. POWERUP_MS=0 goes straight to S_FETCH.
- S_FETCH: rom_addr stable; go to S_WAIT_ROM (1-cycle ROM latency).
- S_WAIT_ROM: register rom_data; go to S_DECODE.
- S_DECODE, priority order:
  - Entry 16'hFFFF: go to S_DONE.
  - addr==DELAY_TAG: load the ms count with data (0 means no wait), go to S_DELAY.
  - addr==8'hFE: skip; this address selects the read action in sccb_interface and is not written. Increment rom_addr, go to S_FETCH.
  - Otherwise: drive sccb_addr/sccb_data, go to S_ISSUE.
- S_ISSUE: sccb_start=1 for exactly one enabled cycle; go to S_WAIT_BUSY.
  - sccb_addr and sccb_data are held until sccb_ready returns high.
- S_WAIT_BUSY: wait for sccb_ready=0, then go to S_WAIT_DONE.
- S_WAIT_DONE: wait for sccb_ready=1, then: write_count+1 (saturating), rom_addr+1, go to S_FETCH.
- S_DELAY: count down ms ticks; at 0, rom_addr+1, go to S_FETCH.
- Table wrap: if rom_addr = 2**ROM_AW-1 is consumed without an end marker, go to S_DONE. rom_addr never wraps to 0 within a pass.
- S_DONE: busy<=0, done<=1. Return to S_IDLE the next enabled cycle; done stays 1 there. A new init_start restarts from index 0.
- init_start asserted while busy is ignored.
- Latency: from S_DECODE of a normal entry to sccb_start is 1 enabled cycle; from sccb_ready rising to the next sccb_start is 4 enabled cycles (FETCH, WAIT_ROM, DECODE, ISSUE).

Optional Feature:
- Macro SCCB_SEQ_TIMEOUT_EN.
- When defined:
  - A 24-bit watchdog runs in S_WAIT_BUSY and S_WAIT_DONE.
  - Limit: 16 enabled cycles in S_WAIT_BUSY, 20*CLK_FREQ/100000 in S_WAIT_DONE.
  - On expiry: seq_error<=1 (sticky until next accepted init_start), abort the pass, go to S_DONE with done=1.
- When undefined: no watchdog logic; seq_error is tied 0; waits are unbounded.

Test Plan:
- CLK_FREQ=100000, POWERUP_MS=1, clk_en=1, table {1280,1100,FFFF}, sccb_interface model -> 100 cycles before first fetch; exactly 2 sccb_start pulses with (12,80) then (11,00); write_count=2; done=1, busy=0.
- Table {F005,1234,FFFF} -> sccb_start for (12,34) no earlier than 5 ms ticks (500 cycles at CLK_FREQ=100000) after decoding F005; write_count=1.
- Table {FE55,0A0B,FFFF} -> no start for FE; single write (0A,0B); write_count=1.
- clk_en toggling 1/0 alternately -> same start sequence; every output changes only on enabled cycles; sccb_start is 1 enabled cycle wide.
- rst_n low in S_WAIT_DONE, then release -> all outputs at reset values; new init_start restarts at rom_addr=0.
- With SCCB_SEQ_TIMEOUT_EN, model holds sccb_ready=1 after start -> seq_error=1 after 16 cycles, done=1; without the macro -> FSM stays in S_WAIT_BUSY and seq_error=0.
